// File: rtl/apb_master_bridge.sv
// ---------------------------------------------------------------------------
// apb_master_bridge
//
// APB2 initiator that turns single-beat host commands into APB transfers
// toward two 8-bit slaves. Slave 1 owns the lower half of the address map
// (PADDR[7]=0) and slave 2 the upper half (PADDR[7]=1). The bridge walks the
// IDLE -> SETUP -> ACCESS sequence, stretches ACCESS while the selected slave
// holds PREADY low, and gives up with an error response if the slave never
// answers within TIMEOUT_CYCLES ACCESS cycles.
//
// Parameters:
//   TIMEOUT_CYCLES  ACCESS cycles with PREADY low before abort (1..255)
//
// Ports:
//   PCLK, PRESETn          clock (rising edge) and async active-low reset
//   cmd_valid/cmd_ready    host command handshake
//   cmd_write              1 = write, 0 = read
//   cmd_addr, cmd_wdata    command address (bit 7 selects slave) and data
//   rsp_valid              one-cycle pulse when a transfer finishes
//   rsp_rdata              read data (0 for writes and aborts), held
//   rsp_err                1 = transfer aborted by timeout, held
//   PSEL1, PSEL2           slave selects, at most one high
//   PENABLE, PWRITE        APB enable and direction
//   PADDR, PWDATA          APB address and write data
//   PRDATA1/2, PREADY1/2   per-slave read data and ready
// ---------------------------------------------------------------------------
module apb_master_bridge #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       PSEL1,
  output logic       PSEL2,
  output logic       PENABLE,
  output logic       PWRITE,
  output logic [7:0] PADDR,
  output logic [7:0] PWDATA,
  input  logic [7:0] PRDATA1,
  input  logic [7:0] PRDATA2,
  input  logic       PREADY1,
  input  logic       PREADY2
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  // The abort fires on the ACCESS cycle whose wait count already equals this
  // value, so exactly TIMEOUT_CYCLES stalled ACCESS cycles are tolerated.
  localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT_CYCLES - 1);

  state_t     state;
  state_t     state_next;
  logic [7:0] wait_cnt;

  logic       sel;
  logic       pready_sel;
  logic [7:0] prdata_sel;
  logic       accept;
  logic       complete;
  logic       abort;

  // Slave steering: the registered address picks which slave's ready and
  // read data are listened to; the other slave's signals are ignored.
  always_comb begin
    sel        = PADDR[7];
    pready_sel = sel ? PREADY2 : PREADY1;
    prdata_sel = sel ? PRDATA2 : PRDATA1;
  end

  // Next-state and handshake decode. cmd_ready in ACCESS follows the selected
  // PREADY, which also guarantees no command is taken on an abort edge
  // (an abort only happens while PREADY is low).
  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    complete   = 1'b0;
    abort      = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          state_next = ST_SETUP;
        end
      end
      ST_SETUP: begin
        state_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (pready_sel) begin
          complete   = 1'b1;
          cmd_ready  = 1'b1;
          state_next = cmd_valid ? ST_SETUP : ST_IDLE;
        end else if (wait_cnt == WAIT_LIMIT) begin
          abort      = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign accept = cmd_valid && cmd_ready;

  // APB control strobes decode straight from the state register so that an
  // asynchronous reset drops them immediately, without waiting for an edge.
  assign PSEL1   = (state != ST_IDLE) && !sel;
  assign PSEL2   = (state != ST_IDLE) && sel;
  assign PENABLE = (state == ST_ACCESS);

  // State register.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Command capture: address, data and direction are loaded only on an
  // accepting edge, so they stay put through SETUP/ACCESS and hold in IDLE.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      PADDR  <= 8'h00;
      PWDATA <= 8'h00;
      PWRITE <= 1'b0;
    end else if (accept) begin
      PADDR  <= cmd_addr;
      PWDATA <= cmd_wdata;
      PWRITE <= cmd_write;
    end
  end

  // Wait-state counter: restarts for every new transfer and counts stalled
  // ACCESS cycles. The abort compare stops it long before it could wrap.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wait_cnt <= 8'h00;
    end else if (state_next == ST_SETUP) begin
      wait_cnt <= 8'h00;
    end else if (state == ST_ACCESS && !pready_sel) begin
      wait_cnt <= wait_cnt + 8'h01;
    end
  end

  // Response channel: a one-cycle rsp_valid after each completion or abort;
  // rsp_rdata/rsp_err keep their value until the next response.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 8'h00;
    end else begin
      rsp_valid <= complete || abort;
      if (complete) begin
        rsp_err   <= 1'b0;
        rsp_rdata <= PWRITE ? 8'h00 : prdata_sel;
      end else if (abort) begin
        rsp_err   <= 1'b1;
        rsp_rdata <= 8'h00;
      end
    end
  end

endmodule
